// File: rtl/usb_rx_bit_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : usbSIEConstants
//  Description : Receive control codes, SE0 line code and receive FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package usbSIEConstants;

    localparam logic [7:0] RX_DATA_START  = 8'd0;
    localparam logic [7:0] RX_DATA_STREAM = 8'd1;
    localparam logic [7:0] RX_DATA_STOP   = 8'd2;
    localparam logic [7:0] RX_DATA_ERROR  = 8'd3;

    localparam logic [1:0] SE0 = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    function automatic logic is_terminal(input logic [7:0] ctrl);
        return (ctrl == RX_DATA_STOP) || (ctrl == RX_DATA_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_bit_decoder_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_out_reg
//  Description : Single-entry valid/ready record holder with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_out_reg
    import usbSIEConstants::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic [7:0] ctrl_i,
    input  logic       rdy_i,
    input  logic       clrOvf_i,
    output logic [7:0] data_o,
    output logic [7:0] ctrl_o,
    output logic       wen_o,
    output logic       ovf_o
);

    logic [7:0] data_q, data_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic       wen_q, wen_d;
    logic       ovf_q, ovf_d;
    logic       w_accept;
    logic       w_canLoad;

    assign w_accept  = wen_q & rdy_i;
    assign w_canLoad = ~wen_q | w_accept;

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        wen_d  = wen_q;
        ovf_d  = ovf_q;
        if (clrOvf_i) begin
            ovf_d = 1'b0;
        end
        if (w_accept) begin
            wen_d = 1'b0;
        end
        if (load_i) begin
            // Terminating records replace a stalled one so the packet end is never lost.
            if (w_canLoad || is_terminal(ctrl_i)) begin
                data_d = data_i;
                ctrl_d = ctrl_i;
                wen_d  = 1'b1;
            end
            if (!w_canLoad) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= 8'd0;
            ctrl_q <= 8'd0;
            wen_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            wen_q  <= wen_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;
    assign wen_o  = wen_q;
    assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/usb_rx_bit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_bit_decoder
//  Description : USB receive SYNC detect, NRZI decode, unstuff, byte assembly.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_bit_decoder
    import usbSIEConstants::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] JBit,
    input  logic [1:0] KBit,
    input  logic [1:0] RxWireData,
    input  logic       RxWireWEn,
    output logic [7:0] RxByte,
    output logic [7:0] RxCtrl,
    output logic       RxByteWEn,
    input  logic       RxByteRdy,
    output logic       RxStuffErr,
    output logic       RxAlignErr,
    output logic       RxOverflow,
    output logic       RxActive
);

    rx_state_e  state_q, state_d;
    logic [1:0] prevLine_q, prevLine_d;
    logic [2:0] zeroCnt_q, zeroCnt_d;
    logic [2:0] oneCnt_q, oneCnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic       firstByte_q, firstByte_d;
    logic       stuffErr_q, stuffErr_d;
    logic       alignErr_q, alignErr_d;
    logic       errSe0_q, errSe0_d;

    logic       w_se0;
    logic       w_isJ;
    logic       w_isK;
    logic       w_bit;
    logic       w_syncStart;
    logic [7:0] w_byte;
    logic       recLoad;
    logic [7:0] recData;
    logic [7:0] recCtrl;

    assign w_se0       = (RxWireData == SE0);
    assign w_isJ       = (RxWireData == JBit);
    assign w_isK       = (RxWireData == KBit);
    assign w_bit       = (RxWireData == prevLine_q);
    assign w_syncStart = RxWireWEn && (state_q == ST_IDLE) && w_isK;

    always_comb begin
        state_d     = state_q;
        prevLine_d  = prevLine_q;
        zeroCnt_d   = zeroCnt_q;
        oneCnt_d    = oneCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        firstByte_d = firstByte_q;
        stuffErr_d  = stuffErr_q;
        alignErr_d  = alignErr_q;
        errSe0_d    = errSe0_q;
        recLoad     = 1'b0;
        recData     = 8'd0;
        recCtrl     = RX_DATA_STREAM;
        w_byte      = shift_q;
        w_byte[bitCnt_q] = w_bit;

        if (RxWireWEn) begin
            if (!w_se0) begin
                prevLine_d = RxWireData;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_isK) begin
                        state_d    = ST_SYNC;
                        zeroCnt_d  = 3'd1;
                        stuffErr_d = 1'b0;
                        alignErr_d = 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (w_se0) begin
                        state_d = ST_IDLE;
                    end else if (!w_bit) begin
                        zeroCnt_d = (zeroCnt_q == 3'd7) ? 3'd7 : zeroCnt_q + 3'd1;
                    end else if ({29'd0, zeroCnt_q} >= SYNC_MIN_ZEROS) begin
                        // The closing SYNC '1' counts toward the first stuffing run.
                        state_d     = ST_DATA;
                        bitCnt_d    = 3'd0;
                        oneCnt_d    = 3'd1;
                        firstByte_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (w_se0) begin
                        state_d = ST_EOP;
                        if (bitCnt_q != 3'd0) begin
                            alignErr_d = 1'b1;
                        end
                    end else if (oneCnt_q == 3'd6) begin
                        if (!w_bit) begin
                            oneCnt_d = 3'd0;
                        end else begin
                            stuffErr_d = 1'b1;
                            state_d    = ST_ERR;
                            errSe0_d   = 1'b0;
                            recLoad    = 1'b1;
                            recCtrl    = RX_DATA_ERROR;
                        end
                    end else begin
                        shift_d  = w_byte;
                        oneCnt_d = w_bit ? oneCnt_q + 3'd1 : 3'd0;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            recLoad     = 1'b1;
                            recData     = w_byte;
                            recCtrl     = firstByte_q ? RX_DATA_START : RX_DATA_STREAM;
                            firstByte_d = 1'b0;
                        end
                    end
                end
                ST_EOP: begin
                    if (w_se0) begin
                        state_d = ST_EOP;
                    end else if (w_isJ) begin
                        state_d = ST_IDLE;
                        recLoad = 1'b1;
                        recCtrl = alignErr_q ? RX_DATA_ERROR : RX_DATA_STOP;
                    end else begin
                        state_d  = ST_ERR;
                        errSe0_d = 1'b0;
                        recLoad  = 1'b1;
                        recCtrl  = RX_DATA_ERROR;
                    end
                end
                ST_ERR: begin
                    if (w_se0) begin
                        errSe0_d = 1'b1;
                    end else begin
                        if (errSe0_q && w_isJ) begin
                            state_d = ST_IDLE;
                        end
                        errSe0_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            prevLine_q  <= JBit;
            zeroCnt_q   <= 3'd0;
            oneCnt_q    <= 3'd0;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            firstByte_q <= 1'b0;
            stuffErr_q  <= 1'b0;
            alignErr_q  <= 1'b0;
            errSe0_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prevLine_q  <= prevLine_d;
            zeroCnt_q   <= zeroCnt_d;
            oneCnt_q    <= oneCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            firstByte_q <= firstByte_d;
            stuffErr_q  <= stuffErr_d;
            alignErr_q  <= alignErr_d;
            errSe0_q    <= errSe0_d;
        end
    end

    usb_rx_out_reg u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (recLoad),
        .data_i   (recData),
        .ctrl_i   (recCtrl),
        .rdy_i    (RxByteRdy),
        .clrOvf_i (w_syncStart),
        .data_o   (RxByte),
        .ctrl_o   (RxCtrl),
        .wen_o    (RxByteWEn),
        .ovf_o    (RxOverflow)
    );

    assign RxStuffErr = stuffErr_q;
    assign RxAlignErr = alignErr_q;
    assign RxActive   = (state_q == ST_DATA) || (state_q == ST_EOP);

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_bit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_bit_decoder
//  Description : Self-checking bench: NRZI/stuffing line encoder plus record model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_bit_decoder;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [7:0] C_START  = 8'd0;
    localparam logic [7:0] C_STREAM = 8'd1;
    localparam logic [7:0] C_STOP   = 8'd2;
    localparam logic [7:0] C_ERROR  = 8'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] JBit;
    logic [1:0] KBit;
    logic [1:0] RxWireData;
    logic       RxWireWEn;
    logic [7:0] RxByte;
    logic [7:0] RxCtrl;
    logic       RxByteWEn;
    logic       RxByteRdy;
    logic       RxStuffErr;
    logic       RxAlignErr;
    logic       RxOverflow;
    logic       RxActive;

    assign JBit = LJ;
    assign KBit = LK;

    always #5 clk = ~clk;

    usb_rx_bit_decoder #(.SYNC_MIN_ZEROS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .JBit       (JBit),
        .KBit       (KBit),
        .RxWireData (RxWireData),
        .RxWireWEn  (RxWireWEn),
        .RxByte     (RxByte),
        .RxCtrl     (RxCtrl),
        .RxByteWEn  (RxByteWEn),
        .RxByteRdy  (RxByteRdy),
        .RxStuffErr (RxStuffErr),
        .RxAlignErr (RxAlignErr),
        .RxOverflow (RxOverflow),
        .RxActive   (RxActive)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
        logic       chk_d;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          gap      = 3;
    int          ones     = 0;
    logic [1:0]  lvl      = LJ;
    logic [7:0]  pkt[4];
    int          npkt     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every handshake is matched against the next modelled record.
    task automatic compare_outputs();
        exp_t e;
        if (rst && RxByteWEn && RxByteRdy) begin
            got_q.push_back({RxByte, RxCtrl});
            chk("record_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("record_ctrl", 32'(RxCtrl), 32'(e.c));
                if (e.chk_d) begin
                    chk("record_byte", 32'(RxByte), 32'(e.d));
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [1:0] v);
        RxWireData = v;
        RxWireWEn  = 1'b1;
        cycle();
        RxWireWEn  = 1'b0;
        repeat (gap) cycle();
    endtask

    task automatic send_bit(input logic b);
        if (!b) lvl = (lvl == LJ) ? LK : LJ;
        sample(lvl);
    endtask

    task automatic send_sync();
        lvl = LJ;
        repeat (7) send_bit(1'b0);
        send_bit(1'b1);
        ones = 1;
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            send_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_eop();
        sample(LSE0);
        sample(LSE0);
        lvl = LJ;
        sample(LJ);
    endtask

    task automatic expect_rec(input logic [7:0] d, input logic [7:0] c, input logic chkd);
        exp_q.push_back('{d: d, c: c, chk_d: chkd});
    endtask

    task automatic packet();
        for (int i = 0; i < npkt; i++) expect_rec(pkt[i], (i == 0) ? C_START : C_STREAM, 1'b1);
        expect_rec(8'h00, C_STOP, 1'b1);
        send_sync();
        for (int i = 0; i < npkt; i++) send_byte(pkt[i]);
        send_eop();
    endtask

    task automatic settle();
        repeat (6) cycle();
        chk("records_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        RxWireData = LJ;
        RxWireWEn  = 1'b0;
        RxByteRdy  = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        chk("reset_outputs", {9'd0, RxByte, RxCtrl, RxByteWEn, RxStuffErr, RxAlignErr, RxOverflow, RxActive}, 32'd0);
        rst = 1'b1;
        cycle();

        // Basic packet 0xA5
        got_q.delete();
        sample(LJ);
        sample(LJ);
        expect_rec(8'hA5, C_START, 1'b1);
        expect_rec(8'h00, C_STOP, 1'b1);
        send_sync();
        cycle();
        chk("active_after_sync", 32'(RxActive), 32'd1);
        send_byte(8'hA5);
        send_eop();
        settle();
        chk("a5_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("a5_rec0", 32'(got_q[0]), 32'h0000_A500);
            chk("a5_rec1", 32'(got_q[1]), 32'h0000_0002);
        end
        chk("a5_flags", {28'd0, RxStuffErr, RxAlignErr, RxOverflow, RxActive}, 32'd0);

        // 0xFF 0x01 with a stuffed zero, back-to-back strobes
        got_q.delete();
        gap = 0;
        pkt[0] = 8'hFF;
        pkt[1] = 8'h01;
        npkt = 2;
        packet();
        gap = 3;
        settle();
        chk("ff01_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("ff01_rec0", 32'(got_q[0]), 32'h0000_FF00);
            chk("ff01_rec1", 32'(got_q[1]), 32'h0000_0101);
            chk("ff01_rec2", 32'(got_q[2]), 32'h0000_0002);
        end
        chk("ff01_nostuff", 32'(RxStuffErr), 32'd0);

        // Stuff error then recovery
        got_q.delete();
        expect_rec(8'h00, C_ERROR, 1'b0);
        send_sync();
        repeat (7) sample(lvl);
        cycle();
        chk("stuff_err", 32'(RxStuffErr), 32'd1);
        chk("stuff_inactive", 32'(RxActive), 32'd0);
        send_eop();
        settle();
        chk("stuff_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("stuff_ctrl", 32'(got_q[0][7:0]), 32'd3);
        got_q.delete();
        pkt[0] = 8'h3C;
        npkt = 1;
        packet();
        settle();
        chk("recover_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) chk("recover_rec0", 32'(got_q[0]), 32'h0000_3C00);
        chk("recover_stuff_clr", 32'(RxStuffErr), 32'd0);

        // Alignment error: three residual bits
        got_q.delete();
        expect_rec(8'h00, C_ERROR, 1'b1);
        send_sync();
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        send_eop();
        settle();
        chk("align_err", 32'(RxAlignErr), 32'd1);
        chk("align_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("align_rec", 32'(got_q[0]), 32'h0000_0003);

        // Overflow with stalled consumer; STOP overwrites the pending byte
        got_q.delete();
        RxByteRdy = 1'b0;
        expect_rec(8'h00, C_STOP, 1'b1);
        send_sync();
        send_byte(8'h11);
        cycle();
        chk("ovf_first_held", {15'd0, RxByteWEn, RxByte, RxCtrl}, {15'd0, 1'b1, 8'h11, 8'h00});
        chk("ovf_clear_yet", 32'(RxOverflow), 32'd0);
        send_byte(8'h22);
        chk("ovf_still_11", {16'd0, RxByte, RxCtrl}, 32'h0000_1100);
        chk("ovf_set", 32'(RxOverflow), 32'd1);
        send_eop();
        chk("ovf_stop_over", {15'd0, RxByteWEn, RxByte, RxCtrl}, {15'd0, 1'b1, 8'h00, 8'h02});
        RxByteRdy = 1'b1;
        settle();
        chk("ovf_wen_drop", 32'(RxByteWEn), 32'd0);
        chk("ovf_sticky", 32'(RxOverflow), 32'd1);
        chk("ovf_count", 32'(got_q.size()), 32'd1);

        // Reset in mid-packet, then a fresh packet
        got_q.delete();
        send_sync();
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        send_data_bit(1'b1);
        chk("mid_active", 32'(RxActive), 32'd1);
        rst = 1'b0;
        cycle();
        chk("mid_reset_outputs", {9'd0, RxByte, RxCtrl, RxByteWEn, RxStuffErr, RxAlignErr, RxOverflow, RxActive}, 32'd0);
        rst = 1'b1;
        cycle();
        sample(LJ);
        pkt[0] = 8'h5A;
        npkt = 1;
        packet();
        settle();
        chk("fresh_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("fresh_rec0", 32'(got_q[0]), 32'h0000_5A00);
            chk("fresh_rec1", 32'(got_q[1]), 32'h0000_0002);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
